// File: rtl/ntt_r4_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : ntt_r4_sequencer_if
//  Purpose  : Bundles the start/done handshake and the coefficient RAM,
//             twiddle ROM and butterfly-datapath control lines of the
//             radix-4 NTT sequencer.
//  Ports    : start, mode                  - transform request and NTT/INTT mode
//             busy, done                   - progress and completion pulse
//             sel, stage                   - latched mode and stage index
//             rd_en, rd_addr, tw_addr      - butterfly issue and read addresses
//             wr_en, wr_addr               - delayed write-back strobe/addresses
//             stall                        - only with NTT_R4_SEQ_STALL_EN
//  Modports : master (requester side), slave (sequencer side)
//  Macro    : NTT_R4_SEQ_STALL_EN adds the stall input
//  Revision : 1.0 - initial release
// ============================================================================
interface ntt_r4_sequencer_if #(
    parameter int N_LOG4 = 4,
    parameter int ADDR_W = 2*N_LOG4
);
    localparam int c_stage_w = (N_LOG4 < 2) ? 2 : N_LOG4;

    logic                  start;
    logic                  mode;
    logic                  busy;
    logic                  done;
    logic                  sel;
    logic [c_stage_w-1:0]  stage;
    logic                  rd_en;
    logic [4*ADDR_W-1:0]   rd_addr;
    logic [ADDR_W-3:0]     tw_addr;
    logic                  wr_en;
    logic [4*ADDR_W-1:0]   wr_addr;

`ifdef NTT_R4_SEQ_STALL_EN
    logic                  stall;

    modport master (
        output start, mode, stall,
        input  busy, done, sel, stage, rd_en, rd_addr, tw_addr, wr_en, wr_addr
    );
    modport slave (
        input  start, mode, stall,
        output busy, done, sel, stage, rd_en, rd_addr, tw_addr, wr_en, wr_addr
    );
`else
    modport master (
        output start, mode,
        input  busy, done, sel, stage, rd_en, rd_addr, tw_addr, wr_en, wr_addr
    );
    modport slave (
        input  start, mode,
        output busy, done, sel, stage, rd_en, rd_addr, tw_addr, wr_en, wr_addr
    );
`endif
endinterface
`default_nettype wire

// File: rtl/ntt_r4_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : ntt_r4_sequencer
//  Purpose  : Control sequencer for a radix-4 NTT/INTT butterfly datapath.
//             Issues one butterfly per cycle per stage (four coefficient
//             read addresses plus a twiddle address), replays the reads as
//             writes PIPE_LAT cycles later and leaves a PIPE_LAT-cycle drain
//             gap between stages.
//  Ports    : clk   - system clock, rising edge
//             rst_n - synchronous active-low reset
//             bus   - ntt_r4_sequencer_if.slave (handshake, addresses, strobes)
//  Macro    : NTT_R4_SEQ_STALL_EN - adds bus.stall, which freezes the
//             sequencer outside IDLE and masks rd_en/wr_en/done meanwhile
//  Revision : 1.0 - initial release
// ============================================================================
module ntt_r4_sequencer #(
    parameter int N_LOG4   = 4,
    parameter int PIPE_LAT = 6,
    parameter int ADDR_W   = 2*N_LOG4
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    ntt_r4_sequencer_if.slave  bus
);
    localparam int c_stage_w = (N_LOG4 < 2) ? 2 : N_LOG4;
    localparam int c_b_w     = ADDR_W - 2;
    localparam int c_lane_w  = 4*ADDR_W;

    localparam logic [c_stage_w-1:0] c_last_stage = c_stage_w'(N_LOG4 - 1);
    localparam logic [c_b_w-1:0]     c_b_ones     = '1;
    localparam logic [4:0]           c_wait_last  = 5'(PIPE_LAT - 1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_wait = 2'd2;
    localparam logic [1:0] c_fin  = 2'd3;

    logic [1:0]            r_state;
    logic [c_stage_w-1:0]  r_s;
    logic [c_b_w-1:0]      r_b;
    logic [4:0]            r_wcnt;
    logic                  r_sel;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_rd_en;
    logic [c_lane_w-1:0]   r_rd_addr;
    logic [c_b_w-1:0]      r_tw_addr;
    logic                  r_dl_en   [PIPE_LAT];
    logic [c_lane_w-1:0]   r_dl_addr [PIPE_LAT];

    logic [1:0]            w_state_nx;
    logic [c_stage_w-1:0]  w_s_nx;
    logic [c_b_w-1:0]      w_b_nx;
    logic [4:0]            w_wcnt_nx;
    logic                  w_sel_nx;
    logic                  w_issue_nx;
    logic                  w_hold;

    logic [c_stage_w-1:0]  w_ld;
    logic [c_stage_w:0]    w_sh;
    logic [c_stage_w:0]    w_tw_sh;
    logic [c_b_w-1:0]      w_k;
    logic [ADDR_W-1:0]     w_base;
    logic [c_lane_w-1:0]   w_rd_addr_nx;
    logic [c_b_w-1:0]      w_tw_nx;

`ifdef NTT_R4_SEQ_STALL_EN
    assign w_hold = bus.stall && (r_state != c_idle);
`else
    assign w_hold = 1'b0;
`endif

    // Next-state and counter update; the output registers are loaded from
    // these next values so the strobes line up with the state they describe.
    always_comb begin
        w_state_nx = r_state;
        w_s_nx     = r_s;
        w_b_nx     = r_b;
        w_wcnt_nx  = r_wcnt;
        w_sel_nx   = r_sel;
        w_issue_nx = 1'b0;
        case (r_state)
            c_idle: begin
                if (bus.start) begin
                    w_state_nx = c_run;
                    w_sel_nx   = bus.mode;
                    w_s_nx     = '0;
                    w_b_nx     = '0;
                    w_issue_nx = 1'b1;
                end
            end
            c_run: begin
                if (r_b == c_b_ones) begin
                    w_state_nx = c_wait;
                    w_wcnt_nx  = '0;
                end else begin
                    w_b_nx     = r_b + 1'b1;
                    w_issue_nx = 1'b1;
                end
            end
            c_wait: begin
                if (r_wcnt == c_wait_last) begin
                    if (r_s == c_last_stage) begin
                        w_state_nx = c_fin;
                    end else begin
                        w_state_nx = c_run;
                        w_s_nx     = r_s + 1'b1;
                        w_b_nx     = '0;
                        w_issue_nx = 1'b1;
                    end
                end else begin
                    w_wcnt_nx = r_wcnt + 1'b1;
                end
            end
            default: begin
                w_state_nx = c_idle;
                w_s_nx     = '0;
            end
        endcase
    end

    // Address generation. d = 4^ld, so every divide/multiply by d is a shift
    // by 2*ld: k keeps the low 2*ld bits of b, and j*4d is b with those bits
    // cleared shifted up by two. The twiddle stride N/(4d) = 4^(S-1-ld).
    always_comb begin
        w_ld    = w_sel_nx ? w_s_nx : (c_last_stage - w_s_nx);
        w_sh    = {w_ld, 1'b0};
        w_tw_sh = {c_last_stage - w_ld, 1'b0};
        w_k     = w_b_nx & ~(c_b_ones << w_sh);
        w_base  = {(w_b_nx & (c_b_ones << w_sh)), 2'b00} | {2'b00, w_k};
        w_tw_nx = w_k << w_tw_sh;
        w_rd_addr_nx = '0;
        for (int m = 0; m < 4; m++) begin
            w_rd_addr_nx[m*ADDR_W +: ADDR_W] = w_base + (ADDR_W'(m) << w_sh);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= c_idle;
            r_s       <= '0;
            r_b       <= '0;
            r_wcnt    <= '0;
            r_sel     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_tw_addr <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                r_dl_en[i]   <= 1'b0;
                r_dl_addr[i] <= '0;
            end
        end else if (!w_hold) begin
            r_state   <= w_state_nx;
            r_s       <= w_s_nx;
            r_b       <= w_b_nx;
            r_wcnt    <= w_wcnt_nx;
            r_sel     <= w_sel_nx;
            r_busy    <= (w_state_nx != c_idle);
            r_done    <= (w_state_nx == c_fin);
            r_rd_en   <= w_issue_nx;
            r_rd_addr <= w_issue_nx ? w_rd_addr_nx : '0;
            r_tw_addr <= w_issue_nx ? w_tw_nx : '0;
            r_dl_en[0]   <= r_rd_en;
            r_dl_addr[0] <= r_rd_addr;
            for (int i = 1; i < PIPE_LAT; i++) begin
                r_dl_en[i]   <= r_dl_en[i-1];
                r_dl_addr[i] <= r_dl_addr[i-1];
            end
        end
    end

    assign bus.busy    = r_busy;
    assign bus.sel     = r_sel;
    assign bus.stage   = r_s;
    assign bus.rd_addr = r_rd_addr;
    assign bus.tw_addr = r_tw_addr;
    assign bus.wr_addr = r_dl_addr[PIPE_LAT-1];

`ifdef NTT_R4_SEQ_STALL_EN
    // Strobes are masked for the stalled cycle itself so a held butterfly
    // is issued exactly once, when the stall releases.
    assign bus.rd_en = r_rd_en & ~bus.stall;
    assign bus.wr_en = r_dl_en[PIPE_LAT-1] & ~bus.stall;
    assign bus.done  = r_done & ~bus.stall;
`else
    assign bus.rd_en = r_rd_en;
    assign bus.wr_en = r_dl_en[PIPE_LAT-1];
    assign bus.done  = r_done;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ntt_r4_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ntt_r4_sequencer
//  Purpose  : Self-checking bench for ntt_r4_sequencer (N_LOG4=2, PIPE_LAT=6)
//             with a schedule-level reference model and random stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ntt_r4_sequencer;
    localparam int N_LOG4   = 2;
    localparam int PIPE_LAT = 6;
    localparam int AW       = 2*N_LOG4;
    localparam int N        = 1 << (2*N_LOG4);
    localparam int NB       = N/4;
    localparam int S        = N_LOG4;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_err;
    bit   armed;

    // reference model state
    bit   act;
    int   t0;
    int   t_done;
    bit   md_l;
    logic [4*AW-1:0] exp_rd [int];
    logic [AW-3:0]   exp_tw [int];
    logic [4*AW-1:0] exp_wr [int];
    int   dir_ntt;
    int   dir_intt;

    ntt_r4_sequencer_if #(.N_LOG4(N_LOG4)) bus ();

    ntt_r4_sequencer #(
        .N_LOG4   (N_LOG4),
        .PIPE_LAT (PIPE_LAT)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Expected schedule of one transform accepted at cycle ts, from the
    // butterfly-distance formulas with ordinary arithmetic.
    task automatic plan(input int ts, input bit md);
        for (int s = 0; s < S; s++) begin
            for (int b = 0; b < NB; b++) begin
                int d, j, k, base, c;
                logic [4*AW-1:0] a;
                d    = 4 ** (md ? s : (S-1-s));
                j    = b / d;
                k    = b % d;
                base = j*4*d + k;
                c    = ts + 1 + s*(NB + PIPE_LAT) + b;
                a    = '0;
                for (int m = 0; m < 4; m++) a[m*AW +: AW] = AW'(base + m*d);
                exp_rd[c] = a;
                exp_tw[c] = (AW-2)'((k * (N/(4*d))) % NB);
                exp_wr[c + PIPE_LAT] = a;
            end
        end
    endtask

    task automatic check_outputs();
        bit exp_busy, has_rd, has_wr;
        int st;
        exp_busy = act && (cyc > t0) && (cyc <= t_done);
        has_rd   = exp_rd.exists(cyc) != 0;
        has_wr   = exp_wr.exists(cyc) != 0;
        check_val("busy", 32'(bus.busy), 32'(exp_busy));
        check_val("done", 32'(bus.done), 32'(act && cyc == t_done));
        check_val("rd_en", 32'(bus.rd_en), 32'(has_rd));
        if (has_rd) begin
            check_val("rd_addr", 32'(bus.rd_addr), 32'(exp_rd[cyc]));
            check_val("tw_addr", 32'(bus.tw_addr), 32'(exp_tw[cyc]));
        end
        check_val("wr_en", 32'(bus.wr_en), 32'(has_wr));
        if (has_wr) check_val("wr_addr", 32'(bus.wr_addr), 32'(exp_wr[cyc]));
        if (exp_busy) begin
            st = (cyc - t0 - 1) / (NB + PIPE_LAT);
            if (st > S-1) st = S-1;
            check_val("stage", 32'(bus.stage), 32'(st));
            check_val("sel", 32'(bus.sel), 32'(md_l));
        end else begin
            check_val("stage_idle", 32'(bus.stage), 32'd0);
        end
        // hand-derived points for the 16-point configuration
        if (cyc == dir_ntt + 2) begin
            check_val("tp_ntt_s0b1", 32'(bus.rd_addr), 32'h0000D951);
            check_val("tp_ntt_s0b1_tw", 32'(bus.tw_addr), 32'd1);
        end
        if (cyc == dir_ntt + 13) begin
            check_val("tp_ntt_s1b2", 32'(bus.rd_addr), 32'h0000BA98);
            check_val("tp_ntt_s1b2_tw", 32'(bus.tw_addr), 32'd0);
        end
        if (cyc == dir_ntt + 21) check_val("tp_ntt_done", 32'(bus.done), 32'd1);
        if (cyc == dir_ntt + 10) check_val("tp_ntt_lastwr", 32'(bus.wr_en), 32'd1);
        if (cyc == dir_intt + 2) begin
            check_val("tp_intt_s0b1", 32'(bus.rd_addr), 32'h00007654);
            check_val("tp_intt_s0b1_tw", 32'(bus.tw_addr), 32'd0);
        end
        if (cyc == dir_intt + 14) begin
            check_val("tp_intt_s1b3", 32'(bus.rd_addr), 32'h0000FB73);
            check_val("tp_intt_s1b3_tw", 32'(bus.tw_addr), 32'd3);
            check_val("tp_intt_sel", 32'(bus.sel), 32'd1);
        end
    endtask

    task automatic model_update(input bit st, input bit md, input bit rn);
        if (!rn) begin
            act = 1'b0;
            exp_rd.delete();
            exp_tw.delete();
            exp_wr.delete();
            armed = 1'b1;
        end else if (st && (!act || cyc > t_done)) begin
            act    = 1'b1;
            t0     = cyc;
            md_l   = md;
            t_done = cyc + S*(NB + PIPE_LAT) + 1;
            plan(cyc, md);
        end
    endtask

    task automatic run_cycle(input bit st, input bit md, input bit rn);
        bus.start = st;
        bus.mode  = md;
        rst_n     = rn;
        @(negedge clk);
        if (armed) check_outputs();
        model_update(st, md, rn);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int ts;
        cyc = 0; n_cmp = 0; n_err = 0; armed = 1'b0;
        act = 1'b0; t0 = 0; t_done = 0; md_l = 1'b0;
        dir_ntt = -1000; dir_intt = -1000;
        bus.start = 1'b0; bus.mode = 1'b0; rst_n = 1'b0;
`ifdef NTT_R4_SEQ_STALL_EN
        bus.stall = 1'b0;
`endif
        run_cycle(0, 0, 0);
        run_cycle(0, 0, 0);
        run_cycle(0, 0, 1);

        // directed NTT, mode wiggling after latch
        dir_ntt = cyc;
        run_cycle(1, 0, 1);
        for (int i = 0; i < 24; i++) run_cycle(0, 1'($urandom_range(0, 1)), 1);

        // directed INTT
        dir_intt = cyc;
        run_cycle(1, 1, 1);
        for (int i = 0; i < 24; i++) run_cycle(0, 1'($urandom_range(0, 1)), 1);

        // start re-pulsed mid-run with the opposite mode: must be ignored
        ts = cyc;
        run_cycle(1, 0, 1);
        for (int i = 1; i < 26; i++) run_cycle(i == 5, i == 5, 1);

        // reset during stage-0 drain with writes outstanding, then a full run
        ts = cyc;
        run_cycle(1, 0, 1);
        for (int i = 1; i < 8; i++) run_cycle(0, 0, 1);
        run_cycle(0, 0, 0);
        for (int i = 0; i < 10; i++) run_cycle(0, 0, 1);
        run_cycle(1, 1, 1);
        for (int i = 0; i < 24; i++) run_cycle(0, 0, 1);

        // start coincident with reset: reset wins
        run_cycle(1, 0, 0);
        for (int i = 0; i < 4; i++) run_cycle(0, 0, 1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            run_cycle(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 299) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
